// File: rtl/harness_serial_host_if.sv
// Signal bundle between the serial host and whoever drives it:
// the parallel command/response handshake plus the two serial wires
// that run to the wrapper's test_i / test_o pins.
interface harness_serial_host_if #(
    parameter int TX_WIDTH = 574,
    parameter int RX_WIDTH = 1143
);

    logic                start;
    logic [TX_WIDTH-1:0] tx_word;
    logic                busy;
    logic                done;
    logic [RX_WIDTH-1:0] rx_word;
    logic                ser_o;
    logic                ser_i;

    // The host block itself: takes commands, produces responses, owns ser_o
    modport slave (
        input  start,
        input  tx_word,
        input  ser_i,
        output busy,
        output done,
        output rx_word,
        output ser_o
    );

    // The requester side (self-test top, bench, loopback fixture)
    modport master (
        output start,
        output tx_word,
        output ser_i,
        input  busy,
        input  done,
        input  rx_word,
        input  ser_o
    );

endinterface

// File: rtl/harness_serial_host.sv
// Host side of the harness serial link.
// A command word is shifted out MSB first on ser_o, the link then idles
// for WAIT_CYCLES cycles, and RX_WIDTH response bits are shifted in from
// ser_i (first bit lands in the MSB). The finished response is presented
// on rx_word together with a one-cycle done pulse. All outputs are
// registered; reset is synchronous and active-high.
module harness_serial_host #(
    parameter int TX_WIDTH    = 574,
    parameter int RX_WIDTH    = 1143,
    parameter int WAIT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    harness_serial_host_if.slave  bus
);

    // Counter must hold the largest "remaining cycles" value of any phase
    localparam int MAX_TR  = (TX_WIDTH > RX_WIDTH) ? TX_WIDTH : RX_WIDTH;
    localparam int MAX_TRW = (MAX_TR > WAIT_CYCLES) ? MAX_TR : WAIT_CYCLES;
    localparam int MAX_ALL = (MAX_TRW > 2) ? MAX_TRW : 2;
    localparam int CNT_W   = $clog2(MAX_ALL);

    // Per-phase counter load values: the phase ends when the counter reaches 0
    localparam int TX_LOAD   = TX_WIDTH - 1;
    localparam int RX_LOAD   = RX_WIDTH - 1;
    localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] TX_LAST   = TX_LOAD[CNT_W-1:0];
    localparam logic [CNT_W-1:0] RX_LAST   = RX_LOAD[CNT_W-1:0];
    localparam logic [CNT_W-1:0] WAIT_LAST = WAIT_LOAD[CNT_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        TX,
        WAIT,
        RX
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [TX_WIDTH-1:0] tx_sh;
    logic [RX_WIDTH-1:0] rx_sh;
    logic [RX_WIDTH-1:0] rx_next;
    logic [RX_WIDTH-1:0] rx_word_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                ser_o_reg;

    // Response shift value including the bit present on ser_i this cycle
    always_comb begin
        rx_next = (rx_sh << 1) | {{(RX_WIDTH-1){1'b0}}, bus.ser_i};
    end

    // Transaction sequencer: command shift-out, idle gap, response shift-in
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rx_word_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            ser_o_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    ser_o_reg <= 1'b0;
                    if (bus.start) begin
                        tx_sh    <= bus.tx_word;
                        cnt      <= TX_LAST;
                        busy_reg <= 1'b1;
                        state    <= TX;
                    end
                end
                TX: begin
                    ser_o_reg <= tx_sh[TX_WIDTH-1];
                    tx_sh     <= tx_sh << 1;
                    if (cnt == '0) begin
                        if (WAIT_CYCLES > 0) begin
                            cnt   <= WAIT_LAST;
                            state <= WAIT;
                        end else begin
                            cnt   <= RX_LAST;
                            state <= RX;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    ser_o_reg <= 1'b0;
                    if (cnt == '0) begin
                        cnt   <= RX_LAST;
                        state <= RX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX: begin
                    ser_o_reg <= 1'b0;
                    rx_sh     <= rx_next;
                    if (cnt == '0) begin
                        rx_word_reg <= rx_next;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    ser_o_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.rx_word = rx_word_reg;
    assign bus.ser_o   = ser_o_reg;

endmodule
